scoreboard_hazard_unit: RTL

//   Parametrised hazard + forwarding unit for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).

---
 rtl/scoreboard_hazard_unit_if.sv | 27 ++
 rtl/scoreboard_hazard_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage request and hazard/forward response bundle for scoreboard_hazard_unit.
// The master drives the decoded instruction; the slave answers with stall, issue and forward selects.
interface scoreboard_hazard_unit_if #(
  parameter int RW   = 5,
  parameter int NSRC = 2
);
  logic                 id_valid;
  logic [NSRC*RW-1:0]   id_rs;
  logic [NSRC-1:0]      id_use;
  logic [RW-1:0]        id_rd;
  logic                 id_regWrite;
  logic                 id_memRead;
  logic                 flush;
  logic                 stall;
  logic                 issue;
  logic [2*NSRC-1:0]    ex_fwd_sel;

  modport master (
    output id_valid, id_rs, id_use, id_rd, id_regWrite, id_memRead, flush,
    input  stall, issue, ex_fwd_sel
  );

  modport slave (
    input  id_valid, id_rs, id_use, id_rd, id_regWrite, id_memRead, flush,
    output stall, issue, ex_fwd_sel
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Countdown-scoreboard hazard detection and EX-stage forwarding for a 5-stage RV32 pipeline.
// A non-zero cnt[r] means a reader of r in ID would see a value that cannot yet be supplied.
module scoreboard_hazard_unit #(
  parameter int NREGS  = 32,
  parameter int RW     = $clog2(NREGS),
  parameter int NSRC   = 2,
  parameter bit FWD_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  scoreboard_hazard_unit_if.slave   bus,
  output logic [31:0]               stall_count,
  output logic                      fwd_err
);

  // Without forwarding every producer must reach WB before the reader leaves ID.
  localparam logic [1:0] LOAD_CNT = FWD_EN ? 2'd1 : 2'd2;
  localparam logic [1:0] ALU_CNT  = FWD_EN ? 2'd0 : 2'd2;

  typedef struct packed {
    logic [NSRC*RW-1:0] rs;
    logic [NSRC-1:0]    src_use;
    logic [RW-1:0]      rd;
    logic               reg_write;
    logic               mem_read;
  } ex_t;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
  } mem_t;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic          reg_write;
  } wb_t;

  logic [1:0]        cnt [NREGS];
  ex_t               ex_q;
  mem_t              mem_q;
  wb_t               wb_q;
  logic              hazard;
  logic [NSRC-1:0]   mem_hit;
  logic [NSRC-1:0]   wb_hit;
  logic [NSRC-1:0]   err_k;
  logic [2*NSRC-1:0] fwd_sel;

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.id_use[k] && (bus.id_rs[k*RW +: RW] != '0) &&
          (cnt[bus.id_rs[k*RW +: RW]] != 2'd0))
        hazard = 1'b1;
    end
  end

  assign bus.stall = bus.id_valid & ~bus.flush & hazard;
  assign bus.issue = bus.id_valid & ~bus.flush & ~hazard;

  always_comb begin
    mem_hit = '0;
    wb_hit  = '0;
    err_k   = '0;
    fwd_sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      mem_hit[k] = ex_q.src_use[k] && mem_q.reg_write && (mem_q.rd != '0) &&
                   (mem_q.rd == ex_q.rs[k*RW +: RW]);
      wb_hit[k]  = ex_q.src_use[k] && wb_q.reg_write && (wb_q.rd != '0) &&
                   (wb_q.rd == ex_q.rs[k*RW +: RW]);
      if (FWD_EN) begin
        if (mem_hit[k])
          fwd_sel[2*k +: 2] = 2'b01;
        else if (wb_hit[k])
          fwd_sel[2*k +: 2] = 2'b10;
        err_k[k] = mem_hit[k] & mem_q.mem_read;
      end else begin
        err_k[k] = mem_hit[k] | wb_hit[k];
      end
    end
  end

  assign bus.ex_fwd_sel = fwd_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= 2'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
      fwd_err     <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (cnt[r] != 2'd0) cnt[r] <= cnt[r] - 2'd1;
      end
      // Later assignment wins, so the younger writer overrides the decrement.
      if (bus.issue && bus.id_regWrite && (bus.id_rd != '0))
        cnt[bus.id_rd] <= bus.id_memRead ? LOAD_CNT : ALU_CNT;

      if (bus.issue) begin
        ex_q.rs        <= bus.id_rs;
        ex_q.src_use   <= bus.id_use;
        ex_q.rd        <= bus.id_rd;
        ex_q.reg_write <= bus.id_regWrite;
        ex_q.mem_read  <= bus.id_memRead;
      end else begin
        ex_q <= '0;
      end

      mem_q.rd        <= ex_q.rd;
      mem_q.reg_write <= ex_q.reg_write;
      mem_q.mem_read  <= ex_q.mem_read;
      wb_q.rd         <= mem_q.rd;
      wb_q.reg_write  <= mem_q.reg_write;

      if (bus.stall && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
      fwd_err <= fwd_err | (|err_k);
    end
  end

endmodule
